// File: rtl/noc_out_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_out_port_ctrl_if
// Brief    : Request/grant/select/credit bundle between one router output-port
//            controller and its surrounding arbiter, buffers and crossbar.
// Revision : 1.0 - initial release
// ============================================================================
interface noc_out_port_ctrl_if;
   logic [4:0] req;
   logic [4:0] tail;
   logic [4:0] arb_req;
   logic [4:0] arbitration;
   logic       credit_in;
   logic [4:0] sel;
   logic [4:0] pop;
   logic       out_valid;
   logic       credit_err;

   modport master (
      input  req, tail, arbitration, credit_in,
      output arb_req, sel, pop, out_valid, credit_err
   );

   modport slave (
      output req, tail, arbitration, credit_in,
      input  arb_req, sel, pop, out_valid, credit_err
   );
endinterface
`default_nettype wire

// File: rtl/noc_out_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : noc_out_port_ctrl
// Brief    : Wormhole output-port controller: arbitrates head flits, locks the
//            output to the winner until its tail, and tracks downstream credits.
// Revision : 1.0 - initial release
// ============================================================================
module noc_out_port_ctrl #(
   parameter int CREDITS = 4,
   parameter int CNT_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   noc_out_port_ctrl_if.master  bus
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_credits = CNT_W'(CREDITS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [4:0]       r_owner;
   logic [4:0]       w_owner_nxt;
   logic [CNT_W-1:0] r_credit_cnt;
   logic             r_credit_err;

   logic             w_has_credit;
   logic [4:0]       w_arb_req;
   logic [4:0]       w_sel;
   logic             w_out_valid;

   assign w_has_credit = (r_credit_cnt != '0);

   // Outputs are gated by rst_n so they drop the instant reset asserts.
   always_comb begin
      w_arb_req   = 5'b0;
      w_sel       = 5'b0;
      w_out_valid = 1'b0;
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      if (rst_n) begin
         case (r_state)
            ST_IDLE: begin
               if (w_has_credit) begin
                  w_arb_req = bus.req;
               end
               if ($onehot(bus.arbitration) &&
                   ((bus.arbitration & ~w_arb_req) == 5'b0)) begin
                  w_sel       = bus.arbitration;
                  w_out_valid = 1'b1;
                  if ((bus.arbitration & bus.tail) == 5'b0) begin
                     w_state_nxt = ST_LOCKED;
                     w_owner_nxt = bus.arbitration;
                  end
               end
            end
            ST_LOCKED: begin
               // Arbiter request held at zero so its priority does not rotate mid-packet.
               if (((bus.req & r_owner) != 5'b0) && w_has_credit) begin
                  w_sel       = r_owner;
                  w_out_valid = 1'b1;
                  if ((bus.tail & r_owner) != 5'b0) begin
                     w_state_nxt = ST_IDLE;
                     w_owner_nxt = 5'b0;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_owner_nxt = 5'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_owner <= 5'b0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   // A returned credit with the counter already full is a protocol error; the
   // counter saturates and the error flag sticks until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit_cnt <= c_credits;
         r_credit_err <= 1'b0;
      end else begin
         if (bus.credit_in && !w_out_valid) begin
            if (r_credit_cnt == c_credits) begin
               r_credit_err <= 1'b1;
            end else begin
               r_credit_cnt <= r_credit_cnt + CNT_W'(1);
            end
         end else if (w_out_valid && !bus.credit_in) begin
            r_credit_cnt <= r_credit_cnt - CNT_W'(1);
         end
      end
   end

   assign bus.arb_req    = w_arb_req;
   assign bus.sel        = w_sel;
   assign bus.pop        = w_sel;
   assign bus.out_valid  = w_out_valid;
   assign bus.credit_err = r_credit_err;

endmodule
`default_nettype wire
